btn_arbiter: RTL and testbench

BTN_ARBITER -- requirements
Module: btn_arbiter

---
 rtl/btn_pkg.sv | 13 +
 rtl/db_chan.sv | 41 ++++
 rtl/btn_arbiter.sv | 90 +++++++++
 tb/tb_btn_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared defaults and helpers for the button arbiter and its debounce channels.
package btn_pkg;

  localparam int DEFAULT_N      = 2;
  localparam int DEFAULT_NB     = 4;
  localparam int DEFAULT_CODE_W = $clog2(DEFAULT_NB);

  // First index the round-robin search looks at after 'last' was granted.
  function automatic int rr_start(input int last, input int nb);
    return (last + 1) % nb;
  endfunction

endpackage

// File: rtl/db_chan.sv
// Single-button debouncer: the output follows the input only after the input
// has disagreed with it for 2^N consecutive clock edges; a one-cycle tick
// marks each debounced rising edge.
module db_chan
  import btn_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic out,
  output logic tick
);

  logic [N-1:0] cnt;

  // Count disagreeing edges, commit the new level on the 2^N-th one, and
  // pulse tick in the same cycle that a committed level goes 0->1.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt  <= '0;
      out  <= 1'b0;
      tick <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (in != out) begin
        if (cnt == {N{1'b1}}) begin
          out  <= in;
          cnt  <= '0;
          tick <= in;
        end else begin
          cnt <= cnt + N'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/btn_arbiter.sv
// Debounces NB buttons and presents each debounced press as a single event
// on a valid/ready port, granting simultaneous presses round-robin.
module btn_arbiter
  import btn_pkg::*;
#(
  parameter int N  = DEFAULT_N,
  parameter int NB = DEFAULT_NB
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NB-1:0]         btn,
  input  logic                  ready,
  output logic                  valid,
  output logic [$clog2(NB)-1:0] code,
  output logic [NB-1:0]         held,
  output logic                  overflow
);

  localparam int CW = $clog2(NB);

  logic [NB-1:0] tick;
  logic [NB-1:0] pending;
  logic [NB-1:0] pending_nxt;
  logic [CW-1:0] last;
  logic [CW-1:0] winner;
  logic          found;
  logic          slot_free;
  logic          load;
  int            start_idx;

  for (genvar i = 0; i < NB; i++) begin : g_chan
    db_chan #(.N(N)) u_db (
      .clk  (clk),
      .reset(reset),
      .in   (btn[i]),
      .out  (held[i]),
      .tick (tick[i])
    );
  end

  // Round-robin search for the first pending button after the last grant.
  always_comb begin
    found     = 1'b0;
    winner    = '0;
    start_idx = rr_start(int'(last), NB);
    for (int k = 0; k < NB; k++) begin
      if (!found && pending[(start_idx + k) % NB]) begin
        found  = 1'b1;
        winner = CW'((start_idx + k) % NB);
      end
    end
  end

  // Decide whether the output slot takes a new event this edge; a fresh tick
  // on the granted button overrides its clear so that press is not lost.
  always_comb begin
    slot_free   = !valid || ready;
    load        = slot_free && found;
    pending_nxt = pending;
    if (load) begin
      pending_nxt[winner] = 1'b0;
    end
    pending_nxt = pending_nxt | tick;
  end

  // Register pending presses, the presented event, the grant pointer and the
  // sticky overflow flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pending  <= '0;
      valid    <= 1'b0;
      code     <= '0;
      last     <= CW'(NB - 1);
      overflow <= 1'b0;
    end else begin
      pending <= pending_nxt;
      if (|(tick & pending)) begin
        overflow <= 1'b1;
      end
      if (load) begin
        valid <= 1'b1;
        code  <= winner;
        last  <= winner;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_btn_arbiter.sv
// Self-checking bench for btn_arbiter (N=2, NB=4): table-driven press patterns
// plus hand-written reset, bounce, backpressure and overflow sequences, with a
// scoreboard of expected event codes consumed at each accepted handshake.
module tb_btn_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] btn;
  logic       ready;
  logic       valid;
  logic [1:0] code;
  logic [3:0] held;
  logic       overflow;

  int checks = 0;
  int errors = 0;
  logic [1:0] expq[$];

  typedef struct {
    logic [3:0] btn;
    int         cycles;
    logic [3:0] exp_held;
    int         n_ev;
    logic [7:0] codes;
  } vec_t;

  vec_t vecs[8];

  btn_arbiter #(.N(2), .NB(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .btn     (btn),
    .ready   (ready),
    .valid   (valid),
    .code    (code),
    .held    (held),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] b, input logic r);
    btn   = b;
    ready = r;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard: every accepted event must match the oldest expected code.
  always @(negedge clk) begin
    if (reset && valid && ready) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_event: got code %0d expected no event at %0t", code, $time);
      end else begin
        checkOutput("event_code", int'(code), int'(expq.pop_front()));
      end
    end
  end

  initial begin
    int bad;
    vecs[0] = '{4'b1011, 10, 4'b1011, 3, 8'h34};
    vecs[1] = '{4'b0000, 10, 4'b0000, 0, 8'h00};
    vecs[2] = '{4'b0001, 10, 4'b0001, 1, 8'h00};
    vecs[3] = '{4'b0101, 10, 4'b0101, 1, 8'h02};
    vecs[4] = '{4'b1111, 10, 4'b1111, 2, 8'h07};
    vecs[5] = '{4'b0000, 10, 4'b0000, 0, 8'h00};
    vecs[6] = '{4'b0110, 10, 4'b0110, 2, 8'h06};
    vecs[7] = '{4'b0000, 10, 4'b0000, 0, 8'h00};

    // Reset with all buttons pressed, then release and watch held rise.
    reset = 1'b0;
    applyStimulus(4'hF, 1'b0);
    step(2);
    checkOutput("reset_valid", valid, 0);
    checkOutput("reset_held", held, 0);
    checkOutput("reset_overflow", overflow, 0);
    reset = 1'b1;
    step(3);
    checkOutput("release_held_early", held, 0);
    step(1);
    checkOutput("release_held_rise", held, 4'hF);
    for (int c = 0; c < 4; c++) expq.push_back(2'(c));
    applyStimulus(4'h0, 1'b1);
    step(12);
    checkOutput("init_drain", expq.size(), 0);
    checkOutput("init_valid", valid, 0);
    checkOutput("init_held", held, 0);

    // Table-driven press patterns with ready held high.
    for (int v = 0; v < 8; v++) begin
      for (int e = 0; e < vecs[v].n_ev; e++) expq.push_back(vecs[v].codes[2*e +: 2]);
      applyStimulus(vecs[v].btn, 1'b1);
      step(vecs[v].cycles);
      checkOutput($sformatf("vec%0d_held", v), held, vecs[v].exp_held);
      checkOutput($sformatf("vec%0d_valid", v), valid, 0);
      checkOutput($sformatf("vec%0d_drain", v), expq.size(), 0);
    end

    // Bouncing button 0 never settles, then a clean press yields one event.
    bad = 0;
    for (int p = 0; p < 5; p++) begin
      applyStimulus(4'b0001, 1'b1);
      for (int s = 0; s < 2; s++) begin step(1); if (held[0] !== 1'b0) bad++; end
      applyStimulus(4'b0000, 1'b1);
      for (int s = 0; s < 2; s++) begin step(1); if (held[0] !== 1'b0) bad++; end
    end
    checkOutput("bounce_glitch", bad, 0);
    expq.push_back(2'd0);
    applyStimulus(4'b0001, 1'b1);
    step(5);
    checkOutput("bounce_valid_early", valid, 0);
    step(1);
    checkOutput("bounce_valid_latency", valid, 1);
    checkOutput("bounce_code", code, 0);
    applyStimulus(4'b0000, 1'b1);
    step(10);
    checkOutput("bounce_drain", expq.size(), 0);

    // Backpressure: event on button 2 must hold steady while ready is low.
    expq.push_back(2'd2);
    applyStimulus(4'b0100, 1'b0);
    step(6);
    checkOutput("bp_valid", valid, 1);
    checkOutput("bp_code", code, 2);
    bad = 0;
    for (int s = 0; s < 10; s++) begin
      step(1);
      if (valid !== 1'b1 || code !== 2'd2 || held !== 4'b0100) bad++;
    end
    checkOutput("bp_stable", bad, 0);
    ready = 1'b1;
    step(1);
    ready = 1'b0;
    checkOutput("bp_release_valid", valid, 0);
    checkOutput("bp_drain", expq.size(), 0);

    // Overflow: slot busy with button 3, button 1 pressed twice.
    expq.push_back(2'd3);
    applyStimulus(4'b1000, 1'b0);
    step(8);
    checkOutput("ovf_slot_valid", valid, 1);
    checkOutput("ovf_slot_code", code, 3);
    applyStimulus(4'b1010, 1'b0);
    step(8);
    checkOutput("ovf_first_press", overflow, 0);
    applyStimulus(4'b1000, 1'b0);
    step(6);
    applyStimulus(4'b1010, 1'b0);
    step(8);
    checkOutput("ovf_second_press", overflow, 1);
    expq.push_back(2'd1);
    ready = 1'b1;
    step(4);
    checkOutput("ovf_valid_after", valid, 0);
    checkOutput("ovf_drain", expq.size(), 0);
    applyStimulus(4'b0000, 1'b1);
    step(10);
    checkOutput("ovf_sticky", overflow, 1);

    // Reset mid-operation with an event presented and others pending.
    applyStimulus(4'hF, 1'b0);
    step(8);
    checkOutput("mid_valid_before", valid, 1);
    reset = 1'b0;
    applyStimulus(4'h0, 1'b0);
    step(1);
    checkOutput("mid_valid", valid, 0);
    checkOutput("mid_held", held, 0);
    checkOutput("mid_overflow", overflow, 0);
    reset = 1'b1;
    ready = 1'b1;
    bad = 0;
    for (int s = 0; s < 15; s++) begin
      step(1);
      if (valid !== 1'b0) bad++;
    end
    checkOutput("mid_no_stale", bad, 0);
    expq.push_back(2'd2);
    applyStimulus(4'b0100, 1'b1);
    step(10);
    checkOutput("mid_fresh_drain", expq.size(), 0);
    checkOutput("mid_fresh_held", held, 4'b0100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
